// File: rtl/pokey_serout_ctrl.sv
// Serial-output controller: buffers one CPU byte and sequences the negedge shift
// chain that frames it as {stop, data, start}, raising need/done interrupt levels.
module pokey_serout_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  localparam int FRAME_W = 1 + DATA_BITS + STOP_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 baud_tick,
  input  logic                 need_ack,
  input  logic                 done_ack,
  output logic                 sr_ld,
  output logic                 sr_en,
  output logic [FRAME_W-1:0]   sr_data,
  output logic                 sr_preset,
  output logic                 busy,
  output logic                 need_irq,
  output logic                 done_irq,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 need_irq_q, need_irq_d;
  logic                 done_irq_q, done_irq_d;
  logic                 overrun_q, overrun_d;

  logic last_tick;
  logic load;
  logic finish;

  // last_tick marks the end of the final stop bit; load covers both the idle
  // load and the back-to-back reload at the end of a frame.
  always_comb begin
    last_tick = (state_q == SHIFT) && baud_tick && (bit_cnt_q == CNT_W'(1));
    load      = !reset && buf_valid_q && ((state_q == IDLE) || last_tick);
    finish    = !reset && last_tick && !buf_valid_q;
  end

  always_comb begin
    sr_ld     = 1'b0;
    sr_en     = 1'b1;
    sr_preset = 1'b1;
    if (!reset) begin
      if (load) begin
        sr_ld     = 1'b1;
        sr_preset = 1'b0;
      end else if ((state_q == SHIFT) && !finish) begin
        sr_preset = 1'b0;
        sr_en     = baud_tick;
      end
    end
  end

  assign sr_data = {{STOP_BITS{1'b1}}, buf_data_q, 1'b0};

  // Flag updates are ordered so that a later assignment wins: ack, then set,
  // then the clear caused by a fresh write.
  always_comb begin
    state_d     = state_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    bit_cnt_d   = bit_cnt_q;
    need_irq_d  = need_irq_q;
    done_irq_d  = done_irq_q;
    overrun_d   = overrun_q;

    if (load) begin
      state_d     = SHIFT;
      bit_cnt_d   = CNT_W'(FRAME_W);
      buf_valid_d = 1'b0;
    end else if (finish) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if ((state_q == SHIFT) && baud_tick) begin
      bit_cnt_d = bit_cnt_q - CNT_W'(1);
    end

    if (need_ack) need_irq_d = 1'b0;
    if (load)     need_irq_d = 1'b1;
    if (done_ack) done_irq_d = 1'b0;
    if (finish)   done_irq_d = 1'b1;

    if (wr_en) begin
      buf_data_d  = wr_data;
      buf_valid_d = 1'b1;
      need_irq_d  = 1'b0;
      done_irq_d  = 1'b0;
      if (buf_valid_q && !load) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      bit_cnt_q   <= '0;
      need_irq_q  <= 1'b0;
      done_irq_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      need_irq_q  <= need_irq_d;
      done_irq_q  <= done_irq_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign need_irq = need_irq_q;
  assign done_irq = done_irq_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_pokey_serout_ctrl.sv
// Bench for pokey_serout_ctrl: models the external negedge shift chains and a
// line receiver whose decoded bytes are scored against the bytes written.
module tb_pokey_serout_ctrl;

  logic       clk;
  logic       reset;
  logic       wr_en, wr_en2;
  logic [7:0] wr_data;
  logic       baud_tick, need_ack, done_ack;

  logic       sr_ld1, sr_en1, sr_preset1, busy1, need1, done1, ovr1;
  logic [9:0] sr_data1;
  logic       sr_ld2, sr_en2, sr_preset2, busy2, need2, done2, ovr2;
  logic [10:0] sr_data2;

  logic [9:0]  chain1;
  logic [10:0] chain2;
  logic        line1, line2, last_line1, last_line2;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rx_n = 0;
  logic [7:0] rx_byte = '0;

  pokey_serout_ctrl #(.DATA_BITS(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .baud_tick(baud_tick), .need_ack(need_ack), .done_ack(done_ack),
    .sr_ld(sr_ld1), .sr_en(sr_en1), .sr_data(sr_data1), .sr_preset(sr_preset1),
    .busy(busy1), .need_irq(need1), .done_irq(done1), .overrun(ovr1)
  );

  pokey_serout_ctrl #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data),
    .baud_tick(baud_tick), .need_ack(need_ack), .done_ack(done_ack),
    .sr_ld(sr_ld2), .sr_en(sr_en2), .sr_data(sr_data2), .sr_preset(sr_preset2),
    .busy(busy2), .need_irq(need2), .done_irq(done2), .overrun(ovr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shift chains: preset forces mark, load takes the frame, shift pulls in 1s.
  always @(negedge clk) begin
    if (sr_preset1)  chain1 <= '1;
    else if (sr_en1) chain1 <= sr_ld1 ? sr_data1 : {1'b1, chain1[9:1]};
    if (sr_preset2)  chain2 <= '1;
    else if (sr_en2) chain2 <= sr_ld2 ? sr_data2 : {1'b1, chain2[10:1]};
  end

  assign line1 = chain1[0];
  assign line2 = chain2[0];

  typedef struct packed {
    logic       rst;
    logic       wr;
    logic [7:0] data;
    logic       tick;
    logic       nack;
    logic       dack;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Receiver: samples the line once per tick interval and rebuilds 8N1 bytes.
  task automatic sample_line();
    logic b;
    b = last_line1;
    if (!rx_active) begin
      if (b == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else if (rx_cnt < 8) begin
      rx_byte[rx_cnt] = b;
      rx_cnt++;
    end else begin
      rx_active = 1'b0;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL rx_unexpected: got 0x%0h expected no frame", rx_byte);
      end else begin
        checkOutput($sformatf("rx_byte%0d", rx_n), {23'd0, b, rx_byte}, {23'd0, 1'b1, exp_q.pop_front()});
      end
      rx_n++;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic wr, input logic [7:0] data,
                               input logic tick, input logic nack, input logic dack,
                               input logic wr2);
    @(posedge clk);
    #1;
    reset     = rst;
    wr_en     = wr;
    wr_en2    = wr2;
    wr_data   = data;
    baud_tick = tick;
    need_ack  = nack;
    done_ack  = dack;
    #2;
    last_line1 = line1;
    last_line2 = line2;
    if (rst) begin
      rx_active = 1'b0;
      rx_cnt    = 0;
    end else if (tick) begin
      sample_line();
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  task automatic tick_cycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick_in(input int n);
    for (int i = 0; i < n; i++) begin
      quiet(15);
      tick_cycle();
    end
  endtask

  task automatic send(input logic [7:0] data, input logic push);
    applyStimulus(1'b0, 1'b1, data, 1'b0, 1'b0, 1'b0, 1'b0);
    if (push) exp_q.push_back(data);
  endtask

  initial begin
    logic [9:0] exp_frame;

    reset = 1'b1; wr_en = 1'b0; wr_en2 = 1'b0; wr_data = '0;
    baud_tick = 1'b0; need_ack = 1'b0; done_ack = 1'b0;

    // {rst, wr, data, tick, nack, dack, expected {ld, en, preset, busy, need, done, overrun}}
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'b0110000};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'b0110000};
    vecs[2]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 7'b0110000};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'b1100000};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'b0001100};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 7'b0001100};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'b0001000};
    vecs[7]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 7'b0001000};
    vecs[8]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 7'b0001000};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'b0001001};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'b0101001};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'b0111001};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'b0110000};

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].tick,
                    vecs[i].nack, vecs[i].dack, 1'b0);
      checkOutput($sformatf("vec%0d", i),
                  {25'd0, sr_ld1, sr_en1, sr_preset1, busy1, need1, done1, ovr1},
                  {25'd0, vecs[i].exp});
    end

    // Single frame of 0xA5, one bit per tick interval.
    send(8'hA5, 1'b1);
    idle();
    checkOutput("t1_load", sr_ld1, 1);
    exp_frame = 10'b1101001010;
    for (int i = 0; i < 10; i++) begin
      quiet(15);
      tick_cycle();
      checkOutput($sformatf("t1_bit%0d", i), last_line1, exp_frame[i]);
    end
    idle();
    checkOutput("t1_end", {done1, busy1, line1}, 3'b101);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    checkOutput("t1_done_ack", done1, 0);

    // Second write during a frame gives a back-to-back reload.
    send(8'h3C, 1'b1);
    idle();
    checkOutput("t2_load", sr_ld1, 1);
    idle();
    checkOutput("t2_need_set", need1, 1);
    tick_in(3);
    send(8'hC3, 1'b1);
    idle();
    checkOutput("t2_need_clr", need1, 0);
    tick_in(6);
    quiet(15);
    tick_cycle();
    checkOutput("t2_b2b_load", {sr_ld1, busy1, done1}, 3'b110);
    idle();
    checkOutput("t2_after_reload", {busy1, need1, done1}, 3'b110);
    tick_in(9);
    quiet(15);
    tick_cycle();
    checkOutput("t2_no_early_done", done1, 0);
    idle();
    checkOutput("t2_done", {busy1, done1}, 2'b01);

    // Write landing on the final tick with an empty buffer.
    send(8'h5A, 1'b1);
    idle();
    tick_in(9);
    quiet(15);
    applyStimulus(1'b0, 1'b1, 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h96);
    checkOutput("t4_final_tick", {sr_ld1, sr_preset1}, 2'b01);
    idle();
    checkOutput("t4_idle_load", {busy1, done1, sr_ld1}, 3'b001);
    idle();
    checkOutput("t4_busy", busy1, 1);
    tick_in(10);
    idle();
    checkOutput("t4_done", done1, 1);

    // Overrun: 0x22 is overwritten by 0x33 and never appears.
    send(8'h11, 1'b1);
    idle();
    send(8'h22, 1'b0);
    idle();
    checkOutput("t3_no_overrun", ovr1, 0);
    send(8'h33, 1'b1);
    idle();
    checkOutput("t3_overrun", ovr1, 1);
    tick_in(20);
    idle();
    checkOutput("t3_done", {done1, busy1, ovr1}, 3'b101);

    // Reset mid-frame aborts and the line returns to mark.
    send(8'h0F, 1'b0);
    idle();
    tick_in(4);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_reset_out", {sr_ld1, sr_en1, sr_preset1}, 3'b011);
    idle();
    checkOutput("t5_after_reset", {busy1, need1, done1, ovr1, sr_preset1, line1}, 6'b000011);
    tick_in(3);
    checkOutput("t5_no_shift", {busy1, last_line1}, 2'b01);

    // Two stop bits on the second instance.
    applyStimulus(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    checkOutput("t6_load", sr_ld2, 1);
    for (int i = 0; i < 11; i++) begin
      quiet(15);
      tick_cycle();
      checkOutput($sformatf("t6_bit%0d", i), last_line2, (i == 0) ? 0 : 1);
      if (i == 10) checkOutput("t6_no_early_done", done2, 0);
    end
    idle();
    checkOutput("t6_done", {done2, busy2}, 2'b10);

    checkOutput("rx_all_received", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pokey_serout_ctrl.md
Name: pokey_serout_ctrl

Overview:
- Sequences the serial-output shift chain: a FRAME_W-long string of load/preset/enable shift cells, clocked on negedge clk, with cell 0 driving the serial line.
- Holds one CPU-written byte in a buffer and frames it as {stop, data, start}.
- Drives the chain's load, enable, parallel-data and preset controls, advancing one bit per baud tick.
- Raises the "output data needed" and "transmission finished" interrupt levels, and sits between the SEROUT register decode and the chain.

Parameters:
- DATA_BITS, 8, data bits per frame.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- FRAME_W, 1+DATA_BITS+STOP_BITS, chain length; derived, not overridden.

Ports:
- clk  in  1  system clock; controller registers on posedge, chain samples on negedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle SEROUT write strobe.
- wr_data  in  DATA_BITS  byte to transmit.
- baud_tick  in  1  one-cycle bit-period pulse from the channel timer.
- need_ack  in  1  clears need_irq.
- done_ack  in  1  clears done_irq.
- sr_ld  out  1  chain load select (Ld).
- sr_en  out  1  chain enable (enn) for the next negedge.
- sr_data  out  FRAME_W  parallel frame; bit 0 = start (0), bits DATA_BITS:1 = data LSB-first, upper bits = stop (1).
- sr_preset  out  1  chain preset P; forces all cells to mark (1).
- busy  out  1  frame in progress.
- need_irq  out  1  level: buffer emptied into chain.
- done_irq  out  1  level: last frame finished with empty buffer.
- overrun  out  1  sticky: a buffered byte was overwritten.

Behaviour:
- Registered state: buf_data, buf_valid, state {IDLE, SHIFT}, bit_cnt (clog2(FRAME_W+1) bits), need_irq, done_irq, overrun.
- sr_* outputs are combinational from state, buf_valid and baud_tick. Chain top-cell D is tied to 1 outside this block.
- Reset (reset=1 at posedge): state=IDLE, buf_valid=0, bit_cnt=0, need_irq=0, done_irq=0, overrun=0, busy=0.
  - While reset=1, outputs are forced: sr_preset=1, sr_en=1, sr_ld=0.
  - Reset mid-frame aborts the frame; the line returns to mark at the next negedge.
- IDLE, buf_valid=0: sr_preset=1, sr_en=1, sr_ld=0 (chain held at all ones). baud_tick is ignored.
- IDLE, buf_valid=1: load cycle.
  - sr_ld=1, sr_en=1, sr_preset=0, sr_data={STOP_BITS ones, buf_data, 0}.
  - At the posedge: buf_valid<=0, need_irq<=1, bit_cnt<=FRAME_W, state<=SHIFT.
  - Load happens on the cycle after buf_valid rises, without waiting for a tick. A baud_tick coinciding with the load is not counted.
- SHIFT, baud_tick=0: sr_en=0, sr_ld=0 (chain holds). busy=1 throughout SHIFT.
- SHIFT, baud_tick=1, bit_cnt>1: shift (sr_en=1, sr_ld=0); bit_cnt decrements by 1.
- SHIFT, baud_tick=1, bit_cnt==1 (end of last stop bit):
  - If buf_valid=1: back-to-back load as in IDLE. State stays SHIFT, bit_cnt<=FRAME_W, need_irq<=1.
  - If buf_valid=0: state<=IDLE, done_irq<=1, sr_preset=1, sr_en=1.
- Each bit is therefore held for exactly one baud_tick interval; start bit duration runs from load to the first tick.
- wr_en: buf_data<=wr_data, buf_valid<=1, need_irq<=0, done_irq<=0.
  - Clear by wr_en has priority over set in the same cycle.
- Overrun:
  - wr_en while buf_valid=1 and the buffer is not consumed that cycle sets overrun; the old byte is lost.
  - wr_en on a load cycle: the chain takes the old byte, the buffer takes the new one, buf_valid stays 1, no overrun.
- Final tick with buf_valid=0 coinciding with wr_en: go IDLE, done_irq stays 0 (clear wins), load on the next cycle.
- need_ack/done_ack clear their flag; a set in the same cycle wins over the ack. overrun clears only on reset.

Test Plan:
- Reset then write 0xA5, ticks every 16 clk: load 1 clk after write; serial line reads 0,1,0,1,0,0,1,0,1,1 across 10 tick intervals; then done_irq=1, busy=0, line=1.
- Write 0x3C, then 0xC3 during the frame: need_irq=1 after the first load, cleared by the second write; at the 10th tick back-to-back load with no idle cycle; done_irq only after the second frame.
- Three writes (0x11, 0x22, 0x33) while busy and the buffer is full: overrun=1, frame 2 transmits 0x33, 0x22 is never seen on the line.
- Write coinciding with the final tick of a frame with empty buffer: IDLE for one cycle, done_irq stays 0, next frame loads on the following cycle.
- reset asserted after the 4th tick of a frame: next cycle busy=0, all flags 0, sr_preset=1, line=1 from the next negedge; no further shifting on subsequent ticks.
- STOP_BITS=2, write 0xFF: line low for 1 interval, high for 10; done_irq after the 11th tick.
